// File: rtl/async_fifo_pkg.sv
// Shared types and constants for the asynchronous FIFO read-side drain engine.
package async_fifo_pkg;

  // Default widths, matching the FIFO this engine drains.
  localparam int FIFO_DSIZE = 32;
  localparam int FIFO_LSIZE = 8;

  // Depth of the output buffer between the FIFO read port and the stream.
  localparam int BUF_DEPTH = 2;

  // Burst engine states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // One buffered word plus its end-of-burst tag, at the default data width.
  typedef struct packed {
    logic                  last;
    logic [FIFO_DSIZE-1:0] data;
  } buf_entry_t;

endpackage

// File: rtl/async_fifo_burst_reader_if.sv
// Bundle of command, FIFO read-port and output-stream signals of the burst reader.
interface async_fifo_burst_reader_if #(
  parameter int DSIZE = 32,
  parameter int LSIZE = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [LSIZE-1:0] cmd_len;
  logic             fifo_rempty;
  logic [DSIZE-1:0] fifo_rdata;
  logic             fifo_rinc;
  logic             m_valid;
  logic             m_ready;
  logic [DSIZE-1:0] m_data;
  logic             m_last;
  logic             busy;

  // The burst engine side.
  modport master (
    input  cmd_valid, cmd_len, fifo_rempty, fifo_rdata, m_ready,
    output cmd_ready, fifo_rinc, m_valid, m_data, m_last, busy
  );

  // The surroundings: command source, FIFO and stream sink.
  modport slave (
    output cmd_valid, cmd_len, fifo_rempty, fifo_rdata, m_ready,
    input  cmd_ready, fifo_rinc, m_valid, m_data, m_last, busy
  );
endinterface

// File: rtl/stream_skid_buffer.sv
// Small valid/ready buffer (BUF_DEPTH entries) with push/pop and occupancy count.
// Push and pop may happen in the same cycle at any occupancy, so a full buffer
// can be refilled on the cycle its head is taken.
module stream_skid_buffer
  import async_fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_DSIZE + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [1:0]       o_count
);

  logic [WIDTH-1:0] r_mem [BUF_DEPTH];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  // A pop only takes effect on a non-empty buffer; a push is refused only when
  // full and nothing leaves in the same cycle.
  assign w_pop_ok  = i_pop && (r_count != 2'd0);
  assign w_push_ok = i_push && ((r_count != 2'(BUF_DEPTH)) || w_pop_ok);

  // Storage: written at the write pointer, cleared on reset so the head reads 0.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_push_ok} - {1'b0, w_pop_ok};
    end
  end

  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/async_fifo_burst_reader.sv
// Read-side drain engine: accepts a burst length, pops exactly that many words
// from the FIFO and streams them out with a last marker. The output buffer keeps
// fifo_rinc free of any combinational dependence on m_ready.
module async_fifo_burst_reader
  import async_fifo_pkg::*;
#(
  parameter int DSIZE = FIFO_DSIZE,
  parameter int LSIZE = FIFO_LSIZE
) (
  input  logic                       clock,
  input  logic                       reset,
  async_fifo_burst_reader_if.master  bus
);

  localparam int EW = DSIZE + 1;

  state_t           r_state;
  state_t           w_state_next;
  logic [LSIZE:0]   r_remaining;
  logic             w_cmd_fire;
  logic             w_pop_fifo;
  logic             w_out_fire;
  logic             w_last_fire;
  logic             w_tag_last;
  logic [EW-1:0]    w_push_entry;
  logic [EW-1:0]    w_head_entry;
  logic             w_buf_valid;
  logic [1:0]       w_buf_count;

  // Commands are only taken while idle; everything is held off during reset.
  assign w_cmd_fire = !reset && (r_state == IDLE) && bus.cmd_valid;

  // Pop depends on registered state and the FIFO empty flag only.
  assign w_pop_fifo = !reset && (r_state == RUN) && (r_remaining != '0) &&
                      !bus.fifo_rempty && (w_buf_count != 2'(BUF_DEPTH));

  // The word popped while one word remains is the final word of the burst.
  assign w_tag_last   = (r_remaining == (LSIZE+1)'(1));
  assign w_push_entry = {w_tag_last, bus.fifo_rdata};

  assign w_out_fire  = !reset && w_buf_valid && bus.m_ready;
  assign w_last_fire = w_out_fire && w_head_entry[DSIZE];

  stream_skid_buffer #(
    .WIDTH (EW)
  ) u_out_buf (
    .i_clk       (clock),
    .i_rst       (reset),
    .i_push      (w_pop_fifo),
    .i_push_data (w_push_entry),
    .i_pop       (w_out_fire),
    .o_valid     (w_buf_valid),
    .o_data      (w_head_entry),
    .o_count     (w_buf_count)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state: RUN until the final pop, DRAIN until the last word leaves.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_cmd_fire) w_state_next = RUN;
      RUN:     if (w_pop_fifo && w_tag_last) w_state_next = DRAIN;
      DRAIN:   if (w_last_fire) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Words still to pop; one bit wider than cmd_len so a full-length burst fits.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_remaining <= '0;
    end else if (w_cmd_fire) begin
      r_remaining <= {1'b0, bus.cmd_len} + (LSIZE+1)'(1);
    end else if (w_pop_fifo) begin
      r_remaining <= r_remaining - (LSIZE+1)'(1);
    end
  end

  // Outputs, all forced low while reset is asserted.
  always_comb begin
    bus.cmd_ready = !reset && (r_state == IDLE);
    bus.busy      = !reset && (r_state != IDLE);
    bus.fifo_rinc = w_pop_fifo;
    bus.m_valid   = !reset && w_buf_valid;
    bus.m_data    = reset ? '0 : w_head_entry[DSIZE-1:0];
    bus.m_last    = !reset && w_buf_valid && w_head_entry[DSIZE];
  end

endmodule

// File: tb/tb_async_fifo_burst_reader.sv
// Directed bench for async_fifo_burst_reader with a queue model of the FIFO.
module tb_async_fifo_burst_reader;

  localparam int DW = 32;
  localparam int LW = 8;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  async_fifo_burst_reader_if #(.DSIZE(DW), .LSIZE(LW)) bus ();

  async_fifo_burst_reader #(.DSIZE(DW), .LSIZE(LW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] fifo_q [$];
  logic [DW-1:0] out_data [$];
  logic          out_last [$];

  int   burst_pops;
  int   outst;
  int   cyc;
  int   first_acc_cyc;
  int   last_acc_cyc;
  logic s_cmd_ready, s_busy, s_rinc, s_mvalid, s_mlast;
  logic [DW-1:0] s_mdata;
  logic prev_last_acc, prev_pop, got_last, bp_mode;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic fifo_refresh();
    bus.fifo_rempty = (fifo_q.size() == 0);
    bus.fifo_rdata  = (fifo_q.size() == 0) ? '0 : fifo_q[0];
  endtask

  task automatic fifo_push(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    fifo_refresh();
  endtask

  // One clock: sample at the falling edge, apply the FIFO pop after the rising edge.
  task automatic step();
    logic acc;
    @(negedge clock);
    s_cmd_ready = bus.cmd_ready;
    s_busy      = bus.busy;
    s_rinc      = bus.fifo_rinc;
    s_mvalid    = bus.m_valid;
    s_mlast     = bus.m_last;
    s_mdata     = bus.m_data;
    if (prev_last_acc && !reset) check_val("ready_after_last", s_cmd_ready, 1);
    if (prev_pop && !reset)      check_val("pop_latency_valid", s_mvalid, 1);
    if (bp_mode) begin
      check_val("bp_outstanding_le2", 64'(outst <= 2), 1);
      if (outst == 2) check_val("bp_no_pop_when_full", s_rinc, 0);
    end
    acc = s_mvalid && bus.m_ready;
    if (acc) begin
      out_data.push_back(s_mdata);
      out_last.push_back(s_mlast);
      if (first_acc_cyc < 0) first_acc_cyc = cyc;
      last_acc_cyc = cyc;
      if (s_mlast) got_last = 1'b1;
    end
    prev_last_acc = acc && s_mlast;
    prev_pop      = s_rinc;
    @(posedge clock);
    #1;
    cyc++;
    if (reset) begin
      outst         = 0;
      prev_last_acc = 1'b0;
      prev_pop      = 1'b0;
    end else begin
      outst = outst + (s_rinc ? 1 : 0) - (acc ? 1 : 0);
    end
    if (s_rinc) begin
      void'(fifo_q.pop_front());
      burst_pops++;
    end
    fifo_refresh();
  endtask

  task automatic begin_burst();
    out_data.delete();
    out_last.delete();
    burst_pops    = 0;
    got_last      = 1'b0;
    first_acc_cyc = -1;
    last_acc_cyc  = -1;
  endtask

  task automatic send_cmd(input int len);
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = LW'(len);
    step();
    check_val("cmd_accept", s_cmd_ready, 1);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_last(input int max_cycles);
    for (int i = 0; i < max_cycles && !got_last; i++) step();
    check_val("burst_done", got_last, 1);
    step();
  endtask

  // Compare the collected stream against base, base+1, ... with last on the final word.
  task automatic check_stream(input string name, input int base, input int n);
    check_val($sformatf("%s_count", name), 64'(out_data.size()), 64'(n));
    for (int i = 0; i < n && i < out_data.size(); i++) begin
      check_val($sformatf("%s_data[%0d]", name, i), out_data[i], 64'(base + i));
      check_val($sformatf("%s_last[%0d]", name, i), out_last[i], 64'(i == n - 1));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_len   = '0;
    bus.m_ready   = 1'b0;
    fifo_refresh();
    outst = 0; cyc = 0; bp_mode = 1'b0;
    prev_last_acc = 1'b0; prev_pop = 1'b0;
    begin_burst();

    // Reset state: every output low while reset is held.
    repeat (3) step();
    check_val("rst_cmd_ready", s_cmd_ready, 0);
    check_val("rst_busy", s_busy, 0);
    check_val("rst_rinc", s_rinc, 0);
    check_val("rst_m_valid", s_mvalid, 0);
    check_val("rst_m_data", s_mdata, 0);
    reset = 1'b0;

    // Idle with an empty FIFO and no command.
    for (int i = 0; i < 20; i++) begin
      step();
      check_val("idle_cmd_ready", s_cmd_ready, 1);
      check_val("idle_busy", s_busy, 0);
      check_val("idle_rinc", s_rinc, 0);
      check_val("idle_m_valid", s_mvalid, 0);
    end
    $display("idle check done at cycle %0d", cyc);

    // Single-word burst.
    bus.m_ready = 1'b1;
    fifo_push(32'hA);
    begin_burst();
    send_cmd(0);
    wait_last(20);
    check_val("single_pops", 64'(burst_pops), 1);
    check_stream("single", 32'hA, 1);
    check_val("single_fifo_empty", 64'(fifo_q.size()), 0);
    $display("single-word burst: %0d words out", out_data.size());

    // Streaming burst of 10 words at full rate.
    for (int i = 0; i < 10; i++) fifo_push(DW'(i));
    begin_burst();
    send_cmd(9);
    wait_last(40);
    check_val("stream_pops", 64'(burst_pops), 10);
    check_stream("stream", 0, 10);
    check_val("stream_rate", 64'(last_acc_cyc - first_acc_cyc), 9);
    check_val("stream_fifo_empty", 64'(fifo_q.size()), 0);
    $display("streaming burst: %0d words out", out_data.size());

    // Back-pressure: m_ready high one cycle in three.
    for (int i = 0; i < 16; i++) fifo_push(DW'(i));
    bus.m_ready = 1'b0;
    bp_mode     = 1'b1;
    begin_burst();
    send_cmd(15);
    for (int i = 0; i < 300 && !got_last; i++) begin
      bus.m_ready = (i % 3 == 0);
      step();
    end
    check_val("bp_done", got_last, 1);
    bp_mode     = 1'b0;
    bus.m_ready = 1'b1;
    step();
    check_val("bp_pops", 64'(burst_pops), 16);
    check_stream("bp", 0, 16);
    check_val("bp_fifo_empty", 64'(fifo_q.size()), 0);
    $display("back-pressure burst: %0d words out", out_data.size());

    // Starvation: 3 of 5 words available, then the rest arrive.
    for (int i = 0; i < 3; i++) fifo_push(DW'(100 + i));
    begin_burst();
    send_cmd(4);
    repeat (10) step();
    check_val("starve_count", 64'(out_data.size()), 3);
    check_val("starve_busy", s_busy, 1);
    check_val("starve_no_last", got_last, 0);
    check_val("starve_pops", 64'(burst_pops), 3);
    fifo_push(DW'(103));
    fifo_push(DW'(104));
    wait_last(20);
    check_stream("starve", 100, 5);
    $display("starved burst: %0d words out", out_data.size());

    // Reset after 5 pops of a 16-word burst; remaining words stay in the FIFO.
    for (int i = 0; i < 16; i++) fifo_push(DW'(i));
    begin_burst();
    send_cmd(15);
    for (int i = 0; i < 40 && burst_pops < 5; i++) step();
    check_val("mid_pops_before_reset", 64'(burst_pops), 5);
    reset       = 1'b1;
    bus.m_ready = 1'b0;
    step();
    check_val("mid_rst_m_valid", s_mvalid, 0);
    check_val("mid_rst_m_data", s_mdata, 0);
    check_val("mid_rst_rinc", s_rinc, 0);
    check_val("mid_rst_cmd_ready", s_cmd_ready, 0);
    reset = 1'b0;
    step();
    check_val("mid_after_m_valid", s_mvalid, 0);
    check_val("mid_after_cmd_ready", s_cmd_ready, 1);
    check_val("mid_after_busy", s_busy, 0);
    check_val("mid_fifo_left", 64'(fifo_q.size()), 11);
    bus.m_ready = 1'b1;
    begin_burst();
    send_cmd(10);
    wait_last(40);
    check_stream("mid_resume", 5, 11);
    check_val("mid_fifo_empty", 64'(fifo_q.size()), 0);
    $display("post-reset burst: %0d words out", out_data.size());

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/async_fifo_burst_reader.md
# async_fifo_burst_reader

Read-side drain engine for the asynchronous FIFO: sits entirely in the FIFO's read clock domain and owns the FIFO read port (`fifo_rinc`/`fifo_rempty`/`fifo_rdata`). Accepts a burst command (word count), pops exactly that many words from the FIFO, and presents them as a valid/ready stream with `m_last` marking the final word. A 2-entry output buffer decouples `fifo_rinc` from downstream back-pressure, so no combinational path runs from `m_ready` to the FIFO.

## Interface
- `DSIZE`, 32, data width, matching the FIFO's DSIZE
- `LSIZE`, 8, burst-length field width; a burst is `cmd_len + 1` words (1..2^LSIZE)

- `clock`  in  1  read-domain clock (same clock as the FIFO read side)
- `reset`  in  1  synchronous, active-high reset
- `cmd_valid`  in  1  burst request valid
- `cmd_ready`  out  1  engine idle, command accepted on `cmd_valid && cmd_ready`
- `cmd_len`  in  LSIZE  burst length minus one
- `fifo_rempty`  in  1  FIFO empty flag
- `fifo_rdata`  in  DSIZE  FIFO head word, show-ahead, valid whenever `!fifo_rempty`
- `fifo_rinc`  out  1  pop FIFO head at this rising edge
- `m_valid`  out  1  output word valid
- `m_ready`  in  1  downstream accepts word
- `m_data`  out  DSIZE  output word
- `m_last`  out  1  final word of the burst
- `busy`  out  1  state != IDLE

## Operation
- FSM states:
  - IDLE: `cmd_ready=1`. On a command handshake, load `remaining = cmd_len + 1` (LSIZE+1 bits) and go to RUN.
  - RUN: pop while permitted. Decrement `remaining` on each pop. After the pop that makes `remaining` 0, go to DRAIN.
  - DRAIN: no pops. Go to IDLE on the edge where the buffered word tagged `last` is accepted (`m_valid && m_ready && m_last`).
- Pop rule: `fifo_rinc = (state==RUN) && (remaining!=0) && !fifo_rempty && (buf_count<2)`. It depends on registers and `fifo_rempty` only, never on `m_ready`.
- A popped word is written into the buffer together with a `last` tag. The tag is 1 iff `remaining==1` at the pop.
- Buffer is a 2-entry FIFO of {last, data}.
  - `m_valid = buf_count!=0`.
  - `m_data` and `m_last` show the head entry.
  - Push and pop in the same cycle are allowed at any count, including count 2 with `fifo_rinc=0`.
- `cmd_valid` outside IDLE is ignored. No queuing of commands.
- `fifo_rempty` during RUN stalls popping. No timeout.
- Reset mid-burst: FSM returns to IDLE, the buffer is discarded, and `remaining` is cleared. Words still in the FIFO stay there. Words in the buffer are lost.

## Timing
- While `reset` is high, all outputs are 0 (`cmd_ready` gated by reset). `m_data` resets to 0.
- The first cycle after reset deasserts: `cmd_ready=1`, `busy=0`.
- Command accepted at edge T: RUN from T+1. Earliest `fifo_rinc` is in cycle T+1.
- Word popped at edge P appears on `m_valid`/`m_data` in cycle P+1 (1-cycle latency).
- Steady state with `m_ready=1` and the FIFO non-empty: 1 word/cycle.
- When `m_ready` drops, at most 2 words are held. Popping resumes the cycle after `buf_count<2`.
- Last word accepted at edge L: IDLE and `cmd_ready=1` in cycle L+1.
- `cmd_len = 2^LSIZE-1` gives 2^LSIZE words. `remaining` must not wrap.

## Structure
- Shared package `async_fifo_pkg`:
  - state enum (IDLE, RUN, DRAIN)
  - buffer entry struct {logic last; logic [DSIZE-1:0] data}
  - `BUF_DEPTH=2`
- Sub-module `stream_skid_buffer`: 2-entry valid/ready buffer with push/pop, count output, and synchronous reset. It is reusable on the write side.
- Top module: FSM, `remaining` counter, pop logic.

## Test plan
- Idle after reset: `fifo_rempty=1`, no command → `cmd_ready=1`, `busy=0`, `fifo_rinc=0`, `m_valid=0` for 20 cycles.
- Single word: FIFO holds 0xA, `cmd_len=0`, `m_ready=1` → one `fifo_rinc` pulse. Next cycle `m_data=0xA`, `m_last=1`. `cmd_ready=1` one cycle after acceptance.
- Streaming: FIFO preloaded with 0..9, `cmd_len=9`, `m_ready=1` → 10 consecutive words 0..9. `m_last` only on 9. Exactly 10 `fifo_rinc` pulses. FIFO ends empty.
- Back-pressure: 16 words 0..15 (FIFO full), `cmd_len=15`, `m_ready` toggled 1-of-3 → in-order 0..15, never more than 2 outstanding pops, `fifo_rinc=0` whenever `buf_count==2`.
- Starvation and partial drain: 3 words in the FIFO, `cmd_len=4` → 3 words out, `busy=1`, stall. Writing 2 more words completes the burst with `m_last` on the 5th word.
- Reset mid-burst: `cmd_len=15`, assert `reset` after 5 pops with `m_ready=0` → next cycle `m_valid=0`, `cmd_ready=1`. A new `cmd_len=10` returns FIFO words 5..15.
